piso_serializer: RTL and testbench

//  Parametrised parallel-in/serial-out serializer with valid/ready input handshake.

---
 rtl/piso_pkg.sv | 26 ++
 rtl/piso_shift_core.sv | 52 +++++
 rtl/piso_serializer.sv | 90 +++++++++
 tb/tb_piso_serializer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and constants for the parametrised PISO serializer.
// Holds the FSM state encoding, the bit-order encoding and a constant-width helper.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic ORDER_LSB = 1'b0;
    localparam logic ORDER_MSB = 1'b1;

    // Number of bits needed to count 0..value-1; used only in constant context.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/piso_shift_core.sv
// Shift register, bit counter and per-word order flag.
// A load restarts the word at bit 0; an advance consumes the current bit.
module piso_shift_core
    import piso_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_msb_first,
    input  logic              advance,
    output logic              bit_out,
    output logic              last
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic              msb_first;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg     <= '0;
            cnt       <= '0;
            msb_first <= ORDER_LSB;
        end else if (load) begin
            shreg     <= load_data;
            cnt       <= '0;
            msb_first <= load_msb_first;
        end else if (advance) begin
            // Consuming the final bit empties the core rather than letting cnt run past the word.
            if (cnt == LAST_CNT) begin
                shreg <= '0;
                cnt   <= '0;
            end else begin
                shreg <= (msb_first == ORDER_MSB) ? {shreg[DATA_W-2:0], 1'b0}
                                                  : {1'b0, shreg[DATA_W-1:1]};
                cnt   <= cnt + 1'b1;
            end
        end
    end

    assign bit_out = (msb_first == ORDER_MSB) ? shreg[DATA_W-1] : shreg[0];
    assign last    = (cnt == LAST_CNT);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready input and a one-word holding buffer.
// The top owns the IDLE/SHIFT FSM, the holding buffer and the handshake.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_msb_first,
    input  logic              bit_en,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              ser_last,
    output logic              busy
);

    localparam int CNT_W = clog2(DATA_W);

    state_t            state;
    logic [DATA_W-1:0] hold_data;
    logic              hold_msb_first;
    logic              hold_full;

    logic core_bit;
    logic core_last;
    logic accept;
    logic consume_last;
    logic core_load;
    logic core_advance;

    assign s_ready      = !reset && !hold_full;
    assign accept       = s_valid && s_ready;
    assign consume_last = (state == SHIFT) && bit_en && core_last;

    // Reload on the final bit comes from the hold if it is full, otherwise straight from the input.
    assign core_load    = ((state == IDLE) && accept) || (consume_last && (hold_full || accept));
    assign core_advance = (state == SHIFT) && bit_en && !core_load;

    piso_shift_core #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_core (
        .clk            (clk),
        .reset          (reset),
        .load           (core_load),
        .load_data      (hold_full ? hold_data : s_data),
        .load_msb_first (hold_full ? hold_msb_first : s_msb_first),
        .advance        (core_advance),
        .bit_out        (core_bit),
        .last           (core_last)
    );

    // NOTE: the holding buffer is a single word, so it is cleared on reset like any
    // other register; a discarded word must never reappear after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            hold_data      <= '0;
            hold_msb_first <= ORDER_LSB;
            hold_full      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) state <= SHIFT;
                end
                SHIFT: begin
                    if (consume_last) begin
                        if (hold_full)   hold_full <= 1'b0;
                        else if (!accept) state    <= IDLE;
                    end else if (accept) begin
                        hold_data      <= s_data;
                        hold_msb_first <= s_msb_first;
                        hold_full      <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ser_valid = (state == SHIFT);
    assign ser_out   = ser_valid && core_bit;
    assign ser_last  = ser_valid && core_last;
    assign busy      = ser_valid || hold_full;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer (DATA_W=8): table-driven vectors plus
// hand-written sequences for back-to-back streaming, slow bit strobe and mid-word reset.
module tb_piso_serializer;

    logic       clk;
    logic       reset;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_msb_first;
    logic       bit_en;
    logic       ser_out;
    logic       ser_valid;
    logic       ser_last;
    logic       busy;

    int checks;
    int failures;

    typedef struct {
        logic       s_valid;
        logic [7:0] s_data;
        logic       msb;
        logic       bit_en;
        logic       e_out;
        logic       e_valid;
        logic       e_last;
        logic       e_ready;
        logic       e_busy;
    } vec_t;

    vec_t vecs[$];

    piso_serializer #(.DATA_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_msb_first (s_msb_first),
        .bit_en      (bit_en),
        .ser_out     (ser_out),
        .ser_valid   (ser_valid),
        .ser_last    (ser_last),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_out, input logic e_valid,
                              input logic e_last, input logic e_ready, input logic e_busy);
        check({tag, " ser_out"},   ser_out,   e_out);
        check({tag, " ser_valid"}, ser_valid, e_valid);
        check({tag, " ser_last"},  ser_last,  e_last);
        check({tag, " s_ready"},   s_ready,   e_ready);
        check({tag, " busy"},      busy,      e_busy);
    endtask

    task automatic drive(input logic sv, input logic [7:0] data, input logic msb, input logic ben);
        s_valid     = sv;
        s_data      = data;
        s_msb_first = msb;
        bit_en      = ben;
    endtask

    // Advance to just after the next rising edge, where inputs for the new cycle are driven.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic sv, input logic [7:0] data, input logic msb, input logic ben,
                       input logic eo, input logic ev, input logic el, input logic er, input logic eb);
        vec_t v;
        v.s_valid = sv;  v.s_data = data; v.msb = msb; v.bit_en = ben;
        v.e_out = eo; v.e_valid = ev; v.e_last = el; v.e_ready = er; v.e_busy = eb;
        vecs.push_back(v);
    endtask

    // Eight shifting cycles with bit_en=1; emitted[7] is the first bit on the line.
    task automatic add_stream(input logic [7:0] emitted);
        for (int k = 0; k < 8; k++)
            add(1'b0, 8'h00, 1'b0, 1'b1, emitted[7-k], 1'b1, (k == 7), 1'b1, 1'b1);
    endtask

    initial begin
        logic [23:0] stream3;
        logic [7:0]  pat4;

        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // 0xB4 LSB-first, then MSB-first, idle with bit_en ignored in between.
        add(1'b1, 8'hB4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        add_stream(8'b00101101);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b1, 8'hB4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        add_stream(8'b10110100);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        // 0x81 LSB-first; 0xB4 MSB-first offered on its last bit goes straight to the shifter.
        add(1'b1, 8'h81, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        add_stream(8'b10000001);
        vecs[$].s_valid = 1'b1;
        vecs[$].s_data  = 8'hB4;
        vecs[$].msb     = 1'b1;
        add_stream(8'b10110100);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset: outputs quiet and s_ready low while reset is held.
        for (int c = 0; c < 3; c++) next_cycle();
        @(negedge clk);
        check_outs("in_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check_outs("post_reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        next_cycle();

        foreach (vecs[i]) begin
            drive(vecs[i].s_valid, vecs[i].s_data, vecs[i].msb, vecs[i].bit_en);
            @(negedge clk);
            check_outs($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_valid,
                       vecs[i].e_last, vecs[i].e_ready, vecs[i].e_busy);
            next_cycle();
        end

        // Back-to-back 0xB4, 0x0F, 0xFF MSB-first with s_valid held: accepts at cycles 0, 1 and 9.
        stream3 = {8'hB4, 8'h0F, 8'hFF};
        for (int c = 0; c <= 25; c++) begin
            if (c == 0)      drive(1'b1, 8'hB4, 1'b1, 1'b1);
            else if (c == 1) drive(1'b1, 8'h0F, 1'b1, 1'b1);
            else if (c <= 9) drive(1'b1, 8'hFF, 1'b1, 1'b1);
            else             drive(1'b0, 8'h00, 1'b1, 1'b1);
            @(negedge clk);
            check_outs($sformatf("b2b c%0d", c),
                       (c >= 1 && c <= 24) ? stream3[24-c] : 1'b0,
                       (c >= 1 && c <= 24),
                       (c == 8 || c == 16 || c == 24),
                       !((c >= 2 && c <= 8) || (c >= 10 && c <= 16)),
                       (c >= 1 && c <= 24));
            next_cycle();
        end

        // 0x81 MSB-first with bit_en every 4th cycle: each bit held for 4 cycles.
        pat4 = 8'b10000001;
        for (int c = 0; c <= 33; c++) begin
            if (c == 0) drive(1'b1, 8'h81, 1'b1, 1'b0);
            else        drive(1'b0, 8'h00, 1'b0, (c % 4 == 0));
            @(negedge clk);
            check_outs($sformatf("slow c%0d", c),
                       (c >= 1 && c <= 32) ? pat4[7 - (c-1)/4] : 1'b0,
                       (c >= 1 && c <= 32),
                       (c >= 29 && c <= 32),
                       1'b1,
                       (c >= 1 && c <= 32));
            next_cycle();
        end

        // Reset while bit 3 of 0xB4 is on the line and 0x0F is held; neither word survives.
        for (int c = 0; c <= 4; c++) begin
            if (c == 0)      drive(1'b1, 8'hB4, 1'b1, 1'b1);
            else if (c == 1) drive(1'b1, 8'h0F, 1'b1, 1'b1);
            else             drive(1'b0, 8'h00, 1'b0, 1'b1);
            if (c == 4) reset = 1'b1;
            @(negedge clk);
            if (c == 1) check("rst_seq hold busy", busy, 1'b1);
            if (c == 4) begin
                check("rst_seq bit3", ser_out, 1'b1);
                check("rst_seq ready_in_reset", s_ready, 1'b0);
            end
            next_cycle();
        end
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check_outs($sformatf("after_rst c%0d", c), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
